// File: rtl/coeff_bank_mem.sv
// coeff_bank_mem: double-buffered per-channel coefficient store.
//
// Each channel owns two banks. The filter reads the active bank and the
// loader writes the shadow bank. A swap flips the two banks of one channel
// in a single edge, so the filter never sees a half-loaded coefficient set.
// A hardware sweep writes zero to the shadow bank of every channel, one
// address per cycle. Swaps requested during a sweep are queued and applied
// when the sweep finishes.
//
// Ports:
//   Sclk      - clock; all logic updates on the rising edge
//   clear     - synchronous active-high reset
//   wr_en     - write strobe into the shadow bank of wr_ch
//   wr_ch     - write channel select
//   wr_addr   - write address
//   wr_data   - write data
//   wr_err    - one-cycle pulse after a rejected write
//   swap_req  - request an active/shadow flip for swap_ch
//   swap_ch   - swap channel select
//   clr_req   - start a shadow-bank clear sweep on all channels
//   clr_busy  - high while the sweep runs
//   rd_en     - read strobe
//   rd_ch     - read channel select
//   rd_addr   - read address into the active bank
//   rd_data   - registered read data (zero for an out-of-range read)
//   rd_valid  - high the cycle after rd_en
//   act_bank  - per-channel active bank index
module coeff_bank_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 1
) (
    input  logic              Sclk,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              swap_req,
    input  logic [CH_W-1:0]   swap_ch,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] act_bank
);

    // Index widths sized to the storage, not to the port widths; ports may
    // be wider so that out-of-range requests can be expressed and rejected.
    localparam int unsigned AIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CIDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [AIDX_W-1:0] LAST_IDX = AIDX_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state;
    logic [AIDX_W-1:0]   cnt;
    logic [NUM_CH-1:0]   pend;

    // Storage: [channel][bank][address]; never reset.
    logic [DATA_W-1:0]   mem [NUM_CH][2][DEPTH];

    logic                wr_ok;
    logic                rd_ok;
    logic                swap_ok;
    logic [CIDX_W-1:0]   wr_ci;
    logic [CIDX_W-1:0]   rd_ci;
    logic [CIDX_W-1:0]   swap_ci;
    logic [AIDX_W-1:0]   wr_ai;
    logic [AIDX_W-1:0]   rd_ai;
    logic [NUM_CH-1:0]   swap_mask;

    // Request decode; indices are only used when the range check passes.
    assign wr_ci   = wr_ch[CIDX_W-1:0];
    assign rd_ci   = rd_ch[CIDX_W-1:0];
    assign swap_ci = swap_ch[CIDX_W-1:0];
    assign wr_ai   = wr_addr[AIDX_W-1:0];
    assign rd_ai   = rd_addr[AIDX_W-1:0];

    assign wr_ok   = wr_en && (32'(wr_ch) < NUM_CH) && (32'(wr_addr) < DEPTH)
                     && (state == IDLE);
    assign rd_ok   = (32'(rd_ch) < NUM_CH) && (32'(rd_addr) < DEPTH);
    assign swap_ok = swap_req && (32'(swap_ch) < NUM_CH);

    // One-hot toggle mask for a valid swap request this cycle.
    always_comb begin
        swap_mask = '0;
        if (swap_ok) begin
            swap_mask[swap_ci] = 1'b1;
        end
    end

    // RAM write port: host writes in IDLE, zero sweep in SWEEP.
    // Both target the shadow bank as it stands before this edge, so a
    // same-cycle swap makes the freshly written word active.
    always_ff @(posedge Sclk) begin
        if (!clear) begin
            if (wr_ok) begin
                mem[wr_ci][~act_bank[wr_ci]][wr_ai] <= wr_data;
            end
            if (state == SWEEP) begin
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    mem[CIDX_W'(c)][~act_bank[CIDX_W'(c)]][cnt] <= '0;
                end
            end
        end
    end

    // Control: read register, error pulse, bank select and clear FSM.
    always_ff @(posedge Sclk) begin
        if (clear) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= '0;
            act_bank <= '0;
            clr_busy <= 1'b0;
            wr_err   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_err   <= wr_en && !wr_ok;
            rd_valid <= rd_en;

            // Reads see the pre-swap active bank.
            if (rd_en) begin
                rd_data <= rd_ok ? mem[rd_ci][act_bank[rd_ci]][rd_ai] : '0;
            end

            case (state)
                IDLE: begin
                    act_bank <= act_bank ^ swap_mask;
                    if (clr_req) begin
                        state    <= SWEEP;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST_IDX) begin
                        // Queued swaps plus any request on the final cycle
                        // each toggle their channel exactly once.
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                        act_bank <= act_bank ^ (pend | swap_mask);
                        pend     <= '0;
                    end else begin
                        cnt  <= cnt + AIDX_W'(1);
                        pend <= pend | swap_mask;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_bank_mem.sv
// Bench for coeff_bank_mem: directed stimulus, reads scored by a queue-based
// monitor, control outputs checked directly against hand-derived values.
module tb_coeff_bank_mem;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned NCH   = 2;
    localparam int unsigned CW    = 2;

    logic          Sclk = 1'b0;
    logic          clear;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err;
    logic          swap_req;
    logic [CW-1:0] swap_ch;
    logic          clr_req;
    logic          clr_busy;
    logic          rd_en;
    logic [CW-1:0] rd_ch;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [NCH-1:0] act_bank;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    int            n;

    always #5 Sclk = ~Sclk;

    coeff_bank_mem #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .NUM_CH (NCH),
        .CH_W   (CW)
    ) dut (
        .Sclk     (Sclk),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .swap_req (swap_req),
        .swap_ch  (swap_ch),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .rd_en    (rd_en),
        .rd_ch    (rd_ch),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .act_bank (act_bank)
    );

    task automatic step();
        @(posedge Sclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_wr(input int ch, input int addr, input int data);
        wr_en   = 1'b1;
        wr_ch   = CW'(ch);
        wr_addr = AW'(addr);
        wr_data = DW'(data);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_rd(input int ch, input int addr, input int exp);
        rd_en   = 1'b1;
        rd_ch   = CW'(ch);
        rd_addr = AW'(addr);
        exp_q.push_back(DW'(exp));
        step();
        rd_en   = 1'b0;
    endtask

    task automatic do_swap(input int ch);
        swap_req = 1'b1;
        swap_ch  = CW'(ch);
        step();
        swap_req = 1'b0;
    endtask

    task automatic start_clr();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    // Counts cycles with clr_busy high, bounded.
    task automatic sweep_wait(output int cnt);
        cnt = 0;
        while (clr_busy && cnt < 2000) begin
            cnt++;
            step();
        end
    endtask

    // Read scoreboard: every rd_valid must match the oldest expected word.
    always @(negedge Sclk) begin
        if (rd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid=1 data 0x%0h, no read pending", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        swap_req = 1'b0; swap_ch = '0; clr_req = 1'b0;
        rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
        repeat (2) step();
        clear = 1'b0;
        repeat (2) step();
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data",  32'(rd_data), 0);
        check("rst_wr_err",   32'(wr_err), 0);
        check("rst_clr_busy", 32'(clr_busy), 0);
        check("rst_act_bank", 32'(act_bank), 0);

        // Zero both banks of both channels; first sweep measures length.
        start_clr();
        check("clr_busy_start", 32'(clr_busy), 1);
        sweep_wait(n);
        check("sweep_len", 32'(n), 512);
        do_swap(0);
        do_swap(1);
        check("act_init_11", 32'(act_bank), 3);
        start_clr();
        sweep_wait(n);
        do_swap(0);
        do_swap(1);
        check("act_init_00", 32'(act_bank), 0);

        // Shadow write is invisible until swap.
        do_wr(0, 5, 16'h1234);
        check("wr_ok_a5", 32'(wr_err), 0);
        do_rd(0, 5, 16'h0000);
        do_swap(0);
        check("act_after_swap0", 32'(act_bank), 1);
        do_rd(0, 5, 16'h1234);

        // Address/channel range on writes.
        do_wr(1, 511, 16'hBEEF);
        check("wr_ok_a511", 32'(wr_err), 0);
        do_wr(1, 512, 16'hDEAD);
        check("wr_err_addr512", 32'(wr_err), 1);
        step();
        check("wr_err_pulse_end", 32'(wr_err), 0);
        do_wr(2, 3, 16'hDEAD);
        check("wr_err_ch2", 32'(wr_err), 1);
        do_swap(1);
        check("act_after_swap1", 32'(act_bank), 3);
        do_rd(1, 0, 16'h0000);
        do_rd(1, 512, 16'h0000);
        do_rd(2, 5, 16'h0000);
        do_rd(1, 511, 16'hBEEF);
        step();
        check("rd_valid_idle", 32'(rd_valid), 0);
        check("rd_data_hold", 32'(rd_data), 32'h0000BEEF);

        // Sweep with write, queued swap and read in flight.
        do_wr(0, 9, 16'h5555);
        start_clr();
        n = 0;
        while (clr_busy && n < 2000) begin
            n++;
            if (n == 10) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_addr = 10'd3; wr_data = 16'h1111;
            end
            if (n == 20) begin
                swap_req = 1'b1; swap_ch = 2'd1;
            end
            if (n == 30) begin
                rd_en = 1'b1; rd_ch = 2'd0; rd_addr = 10'd5;
                exp_q.push_back(16'h1234);
            end
            if (n == 512) check("act_last_sweep_cycle", 32'(act_bank), 3);
            step();
            wr_en = 1'b0; swap_req = 1'b0; rd_en = 1'b0;
            if (n == 10) check("wr_err_busy", 32'(wr_err), 1);
            if (n == 20) check("act_held_in_sweep", 32'(act_bank), 3);
        end
        check("sweep_len2", 32'(n), 512);
        check("pend_swap_applied", 32'(act_bank), 1);
        do_rd(1, 511, 16'h0000);
        do_swap(0);
        check("act_after_swap0b", 32'(act_bank), 0);
        do_rd(0, 9, 16'h0000);

        // Reset at sweep cycle 100 with a swap pending.
        start_clr();
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            if (n == 50) begin
                swap_req = 1'b1; swap_ch = 2'd0;
            end
            step();
            swap_req = 1'b0;
        end
        check("busy_at_100", 32'(clr_busy), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("abort_clr_busy", 32'(clr_busy), 0);
        check("abort_act_bank", 32'(act_bank), 0);
        repeat (3) step();
        check("pend_discarded", 32'(act_bank), 0);
        check("abort_stays_idle", 32'(clr_busy), 0);

        // Write and swap on the same channel, same cycle.
        wr_en = 1'b1; wr_ch = 2'd0; wr_addr = 10'd7; wr_data = 16'h0F0F;
        swap_req = 1'b1; swap_ch = 2'd0;
        step();
        wr_en = 1'b0; swap_req = 1'b0;
        check("act_wr_swap", 32'(act_bank), 1);
        do_rd(0, 7, 16'h0F0F);

        // clr_req together with swap (ch1) and write (ch0).
        do_wr(1, 20, 16'hAAAA);
        clr_req = 1'b1;
        swap_req = 1'b1; swap_ch = 2'd1;
        wr_en = 1'b1; wr_ch = 2'd0; wr_addr = 10'd4; wr_data = 16'h7777;
        step();
        clr_req = 1'b0; swap_req = 1'b0; wr_en = 1'b0;
        check("swap_with_clr", 32'(act_bank), 3);
        check("busy_with_clr", 32'(clr_busy), 1);
        check("wr_with_clr_ok", 32'(wr_err), 0);
        n = 0;
        while (clr_busy && n < 2000) begin
            n++;
            if (n == 5) begin
                rd_en = 1'b1; rd_ch = 2'd1; rd_addr = 10'd20;
                exp_q.push_back(16'hAAAA);
            end
            step();
            rd_en = 1'b0;
        end
        check("sweep_len3", 32'(n), 512);
        do_swap(0);
        check("act_final", 32'(act_bank), 2);
        do_rd(0, 4, 16'h0000);
        do_rd(1, 20, 16'hAAAA);

        repeat (3) step();
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
